// File: rtl/spi_fsm.sv
// spi_fsm: control FSM for an SPI slave. It sequences one address+R/W byte and then one data byte.
// Defining SPI_FSM_TIMEOUT_EN adds an idle-SCLK watchdog.
module spi_fsm #(
   parameter int WORD_BITS      = 8,
   parameter int COUNT_W        = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_cond,
   input  logic       sclk_posedge,
   input  logic       sclk_negedge,
   input  logic       rw_bit,
   output logic       sr_shift,
   output logic       sr_load,
   output logic       addr_we,
   output logic       dm_we,
   output logic       miso_buff,
   output logic [2:0] state,
   output logic       timeout
);
   typedef enum logic [2:0] {
      IDLE, GET_ADDR, LATCH_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE
   } state_t;
   localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WORD_BITS);
   if (2**COUNT_W <= WORD_BITS) begin : g_bad_count_w
      $error("COUNT_W too narrow for WORD_BITS");
   end
   if (2**TO_W <= TIMEOUT_CYCLES) begin : g_bad_to_w
      $error("TO_W too narrow for TIMEOUT_CYCLES");
   end
   state_t state_q, state_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic cnt_edge, cnt_full, to_hit;
   assign cnt_edge = (state_q == READ_SHIFT) ? sclk_negedge :
                     ((state_q == GET_ADDR) || (state_q == WRITE_SHIFT)) ? sclk_posedge : 1'b0;
   assign cnt_inc  = cnt_q + COUNT_W'(cnt_edge);
   assign cnt_full = cnt_inc == LAST;
   // next state; cs high (abort) or watchdog expiry forces IDLE, and the counter restarts on every state change
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:         state_d = cs_cond ? IDLE : GET_ADDR;
         GET_ADDR:     state_d = cnt_full ? LATCH_ADDR : GET_ADDR;
         LATCH_ADDR:   state_d = rw_bit ? READ_LOAD : WRITE_SHIFT;
         READ_LOAD:    state_d = READ_SHIFT;
         READ_SHIFT:   state_d = cnt_full ? DONE : READ_SHIFT;
         WRITE_SHIFT:  state_d = cnt_full ? WRITE_COMMIT : WRITE_SHIFT;
         WRITE_COMMIT: state_d = DONE;
         default:      state_d = DONE;
      endcase
      if (cs_cond || to_hit) state_d = IDLE;
      cnt_d = (state_d != state_q) ? '0 : cnt_inc;
   end
   // state and bit counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`ifdef SPI_FSM_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
   logic [TO_W-1:0] to_q, to_d, to_inc;
   logic timeout_q, watch;
   assign watch  = (state_q == GET_ADDR) || (state_q == READ_SHIFT) || (state_q == WRITE_SHIFT);
   assign to_inc = (!watch || cnt_edge) ? '0 : to_q + 1'b1;
   assign to_hit = to_inc == TO_LIM;
   assign to_d   = (state_d != state_q) ? '0 : to_inc;
   // watchdog counts clocks without a counting edge; expiry gives a one-cycle timeout pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         to_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_q      <= to_d;
         timeout_q <= to_hit;
      end
   end
   assign timeout = timeout_q;
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif
   assign state     = state_q;
   assign sr_shift  = !reset && sclk_posedge && ((state_q == GET_ADDR) || (state_q == WRITE_SHIFT));
   assign sr_load   = state_q == READ_LOAD;
   assign addr_we   = state_q == LATCH_ADDR;
   assign dm_we     = state_q == WRITE_COMMIT;
   assign miso_buff = state_q == READ_SHIFT;
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: scoreboard bench for spi_fsm. Expected state transitions are queued with their cycle and strobes.
module tb_spi_fsm;
   logic clk = 1'b0, reset, cs_cond, sclk_posedge, sclk_negedge, rw_bit;
   logic sr_shift, sr_load, addr_we, dm_we, miso_buff, timeout;
   logic [2:0] state;
   logic [4:0] outs;
   localparam logic [4:0] O_LOAD = 5'b10000, O_ADDR = 5'b01000, O_DM = 5'b00100, O_MISO = 5'b00010, O_TO = 5'b00001;
   localparam logic [2:0] S_IDLE = 3'd0, S_GET = 3'd1, S_LATCH = 3'd2, S_RLOAD = 3'd3, S_RSHIFT = 3'd4,
                          S_WSHIFT = 3'd5, S_COMMIT = 3'd6, S_DONE = 3'd7;
   typedef struct {logic [2:0] st; logic [4:0] o; int cyc;} ev_t;
   ev_t sb[$];
   int n_chk = 0, n_fail = 0, cyc = 0;
   int shift_n = 0, miso_n = 0, dm_n = 0, addr_n = 0, load_n = 0;
   logic mon_en = 1'b0;
   logic [1:0] edge_tab [12] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};

   spi_fsm #(.WORD_BITS(8), .COUNT_W(4), .TIMEOUT_CYCLES(20), .TO_W(8)) dut (
      .clk(clk), .reset(reset), .cs_cond(cs_cond), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
      .rw_bit(rw_bit), .sr_shift(sr_shift), .sr_load(sr_load), .addr_we(addr_we), .dm_we(dm_we),
      .miso_buff(miso_buff), .state(state), .timeout(timeout));

   assign outs = {sr_load, addr_we, dm_we, miso_buff, timeout};
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // monitor: every state change pops one expected {cycle, state, strobes} entry
   initial begin
      logic [2:0] prev;
      ev_t e;
      prev = S_IDLE;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (sr_shift) shift_n++;
            if (miso_buff) miso_n++;
            if (dm_we) dm_n++;
            if (addr_we) addr_n++;
            if (sr_load) load_n++;
            if (state !== prev) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_transition: state %0d outs %b at cycle %0d, none required", state, outs, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("transition{cyc,state,outs}", {8'd0, cyc[15:0], state, outs}, {8'd0, e.cyc[15:0], e.st, e.o});
               end
            end
            prev = state;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input logic [2:0] st, input logic [4:0] o, input int dt);
      sb.push_back('{st, o, cyc + dt});
   endtask

   task automatic pulse(input logic p, input logic n);
      sclk_posedge = p;
      sclk_negedge = n;
      tick(1);
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b0;
      tick(1);
   endtask

   task automatic clr();
      shift_n = 0; miso_n = 0; dm_n = 0; addr_n = 0; load_n = 0;
   endtask

   task automatic start_frame(input logic rw);
      clr();
      rw_bit = rw;
      expect_ev(S_GET, 5'b0, 1);
      cs_cond = 1'b0;
      tick(1);
   endtask

   task automatic addr_byte(input logic rw);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            expect_ev(S_LATCH, O_ADDR, 1);
            if (rw) begin
               expect_ev(S_RLOAD, O_LOAD, 2);
               expect_ev(S_RSHIFT, O_MISO, 3);
            end else expect_ev(S_WSHIFT, 5'b0, 2);
         end
         pulse(1'b1, 1'b0);
      end
   endtask

   task automatic end_frame();
      expect_ev(S_IDLE, 5'b0, 1);
      cs_cond = 1'b1;
      tick(1);
   endtask

   task automatic finish_chk(input string name, input int shifts, input int miso, input int dms, input int addrs, input int loads);
      tick(2);
      chk({name, "_sb_empty"}, 32'(sb.size()), 0);
      chk({name, "_sr_shift_count"}, 32'(shift_n), 32'(shifts));
      chk({name, "_miso_cycles"}, 32'(miso_n), 32'(miso));
      chk({name, "_dm_we_count"}, 32'(dm_n), 32'(dms));
      chk({name, "_addr_we_count"}, 32'(addr_n), 32'(addrs));
      chk({name, "_sr_load_count"}, 32'(load_n), 32'(loads));
      sb.delete();
   endtask

   initial begin
      reset = 1'b1; cs_cond = 1'b1; sclk_posedge = 1'b0; sclk_negedge = 1'b0; rw_bit = 1'b0;
      tick(3);
      chk("reset_state_outs", {24'd0, state, outs}, 0);
      chk("reset_sr_shift", 32'(sr_shift), 0);
      reset = 1'b0;
      tick(1);
      mon_en = 1'b1;
      // write: address 0x12 with W (0x24), then data 0xA5
      start_frame(1'b0);
      addr_byte(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            expect_ev(S_COMMIT, O_DM, 1);
            expect_ev(S_DONE, 5'b0, 2);
         end
         pulse(1'b1, 1'b0);
      end
      tick(2);
      end_frame();
      finish_chk("write", 16, 0, 1, 1, 0);
      // read: address 0x12 with R (0x25); the data byte goes out on negedges
      start_frame(1'b1);
      addr_byte(1'b1);
      tick(1);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) expect_ev(S_DONE, 5'b0, 1);
         pulse(1'b0, 1'b1);
      end
      tick(2);
      end_frame();
      finish_chk("read", 8, 15, 0, 1, 1);
      // abort after 5 data bits
      start_frame(1'b0);
      addr_byte(1'b0);
      for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
      end_frame();
      tick(3);
      finish_chk("abort", 13, 0, 0, 1, 0);
      // edge robustness: negedge-only and coincident pulses mixed into the address byte
      start_frame(1'b0);
      for (int i = 0, p = 0; i < 12; i++) begin
         if (edge_tab[i][1] && p == 7) begin
            expect_ev(S_LATCH, O_ADDR, 1);
            expect_ev(S_WSHIFT, 5'b0, 2);
         end
         if (edge_tab[i][1]) p++;
         pulse(edge_tab[i][1], edge_tab[i][0]);
      end
      end_frame();
      finish_chk("edges", 8, 0, 0, 1, 0);
      // reset in the middle of the address byte
      start_frame(1'b0);
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
      expect_ev(S_IDLE, 5'b0, 1);
      reset = 1'b1;
      tick(1);
      chk("reset_mid_state_outs", {24'd0, state, outs}, 0);
      cs_cond = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      finish_chk("reset_mid", 3, 0, 0, 0, 0);
      // SCLK stalls after 3 address bits
      start_frame(1'b0);
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
`ifdef SPI_FSM_TIMEOUT_EN
      expect_ev(S_IDLE, O_TO, 19);
      expect_ev(S_GET, 5'b0, 20);
      tick(20);
`else
      tick(30);
      chk("stall_holds_get_addr", 32'(state), 32'(S_GET));
      chk("stall_no_timeout", 32'(timeout), 0);
`endif
      end_frame();
      finish_chk("stall", 3, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
